id_pipe: RTL and testbench

Registered, parametrised RV32I/RV64I decode stage sitting between the fetch buffer (`if_id`) and `id_ex`. It generalises the combinational decoder to an XLEN-wide datapath and adds LOAD/STORE decode and an illegal-instruction flag. It adds valid/ready handshakes on both sides, a one-entry output register, a flush input and an internal load-use interlock. Register-file reads remain combinational, issued in the accept cycle.

---
 rtl/id_pipe_pkg.sv | 61 ++++++
 rtl/id_pipe_decode.sv | 148 ++++++++++++++
 rtl/id_pipe.sv | 170 +++++++++++++++++
 tb/tb_id_pipe.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/id_pipe_pkg.sv
// Shared opcode/func3 codes, output-register states and func3 legality helpers
// for the id_pipe decode stage.
package id_pipe_pkg;

  localparam logic [6:0] INST_TYPE_I     = 7'b0010011;
  localparam logic [6:0] INST_TYPE_R     = 7'b0110011;
  localparam logic [6:0] INST_TYPE_B     = 7'b1100011;
  localparam logic [6:0] INST_TYPE_L     = 7'b0000011;
  localparam logic [6:0] INST_TYPE_S     = 7'b0100011;
  localparam logic [6:0] INST_TYPE_JAL   = 7'b1101111;
  localparam logic [6:0] INST_TYPE_JALR  = 7'b1100111;
  localparam logic [6:0] INST_TYPE_LUI   = 7'b0110111;
  localparam logic [6:0] INST_TYPE_AUIPC = 7'b0010111;

  localparam logic [2:0] INST_SLLI = 3'b001;
  localparam logic [2:0] INST_SRI  = 3'b101;
  localparam logic [2:0] INST_JALR = 3'b000;

  localparam logic [2:0] INST_BEQ  = 3'b000;
  localparam logic [2:0] INST_BNE  = 3'b001;
  localparam logic [2:0] INST_BLT  = 3'b100;
  localparam logic [2:0] INST_BGE  = 3'b101;
  localparam logic [2:0] INST_BLTU = 3'b110;
  localparam logic [2:0] INST_BGEU = 3'b111;

  localparam logic [2:0] INST_LB  = 3'b000;
  localparam logic [2:0] INST_LH  = 3'b001;
  localparam logic [2:0] INST_LW  = 3'b010;
  localparam logic [2:0] INST_LD  = 3'b011;
  localparam logic [2:0] INST_LBU = 3'b100;
  localparam logic [2:0] INST_LHU = 3'b101;
  localparam logic [2:0] INST_LWU = 3'b110;

  localparam logic [2:0] INST_SB = 3'b000;
  localparam logic [2:0] INST_SH = 3'b001;
  localparam logic [2:0] INST_SW = 3'b010;
  localparam logic [2:0] INST_SD = 3'b011;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } out_state_e;

  function automatic logic branch_f3_ok(input logic [2:0] f3);
    return (f3 == INST_BEQ) || (f3 == INST_BNE) || (f3 == INST_BLT) ||
           (f3 == INST_BGE) || (f3 == INST_BLTU) || (f3 == INST_BGEU);
  endfunction

  // LD/LWU and SD only exist on RV64.
  function automatic logic load_f3_ok(input logic [2:0] f3, input logic rv64);
    return (f3 == INST_LB) || (f3 == INST_LH) || (f3 == INST_LW) ||
           (f3 == INST_LBU) || (f3 == INST_LHU) ||
           (rv64 && ((f3 == INST_LD) || (f3 == INST_LWU)));
  endfunction

  function automatic logic store_f3_ok(input logic [2:0] f3, input logic rv64);
    return (f3 == INST_SB) || (f3 == INST_SH) || (f3 == INST_SW) ||
           (rv64 && (f3 == INST_SD));
  endfunction

endpackage

// File: rtl/id_pipe_decode.sv
// Combinational RV32I/RV64I field decoder: operands, addresses, write/memory
// enables, illegal flag and which source registers the instruction reads.
module id_decode
  import id_pipe_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     inst_i,
  input  logic [XLEN-1:0] inst_addr_i,
  input  logic [XLEN-1:0] rs1_data_i,
  input  logic [XLEN-1:0] rs2_data_i,
  output logic [XLEN-1:0] op1_o,
  output logic [XLEN-1:0] op2_o,
  output logic [XLEN-1:0] base_addr_o,
  output logic [XLEN-1:0] addr_offset_o,
  output logic [4:0]      rd_addr_o,
  output logic            reg_wen_o,
  output logic            mem_ren_o,
  output logic            mem_wen_o,
  output logic            illegal_o,
  output logic            uses_rs1_o,
  output logic            uses_rs2_o
);

  localparam logic RV64 = (XLEN == 64);

  logic [6:0]      opcode;
  logic [2:0]      func3;
  logic [4:0]      rd;
  logic [5:0]      shamt;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_j, imm_u, shamt_x, four;

  assign opcode  = inst_i[6:0];
  assign func3   = inst_i[14:12];
  assign rd      = inst_i[11:7];
  assign shamt   = RV64 ? inst_i[25:20] : {1'b0, inst_i[24:20]};
  assign shamt_x = {{(XLEN-6){1'b0}}, shamt};
  assign four    = {{(XLEN-3){1'b0}}, 3'd4};

  assign imm_i = {{(XLEN-12){inst_i[31]}}, inst_i[31:20]};
  assign imm_s = {{(XLEN-12){inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
  assign imm_b = {{(XLEN-13){inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25],
                  inst_i[11:8], 1'b0};
  assign imm_j = {{(XLEN-21){inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20],
                  inst_i[30:21], 1'b0};
  assign imm_u = {{(XLEN-31){inst_i[31]}}, inst_i[30:12], 12'b0};

  always_comb begin
    op1_o         = '0;
    op2_o         = '0;
    base_addr_o   = '0;
    addr_offset_o = '0;
    rd_addr_o     = '0;
    reg_wen_o     = 1'b0;
    mem_ren_o     = 1'b0;
    mem_wen_o     = 1'b0;
    illegal_o     = 1'b0;
    uses_rs1_o    = 1'b0;
    uses_rs2_o    = 1'b0;
    case (opcode)
      INST_TYPE_I: begin
        op1_o      = rs1_data_i;
        op2_o      = ((func3 == INST_SLLI) || (func3 == INST_SRI)) ? shamt_x : imm_i;
        rd_addr_o  = rd;
        reg_wen_o  = 1'b1;
        uses_rs1_o = 1'b1;
      end
      INST_TYPE_R: begin
        op1_o      = rs1_data_i;
        op2_o      = rs2_data_i;
        rd_addr_o  = rd;
        reg_wen_o  = 1'b1;
        uses_rs1_o = 1'b1;
        uses_rs2_o = 1'b1;
      end
      INST_TYPE_B: begin
        if (branch_f3_ok(func3)) begin
          op1_o         = rs1_data_i;
          op2_o         = rs2_data_i;
          base_addr_o   = inst_addr_i;
          addr_offset_o = imm_b;
          uses_rs1_o    = 1'b1;
          uses_rs2_o    = 1'b1;
        end else begin
          illegal_o = 1'b1;
        end
      end
      INST_TYPE_JAL: begin
        op1_o         = inst_addr_i;
        op2_o         = four;
        rd_addr_o     = rd;
        reg_wen_o     = 1'b1;
        base_addr_o   = inst_addr_i;
        addr_offset_o = imm_j;
      end
      INST_TYPE_JALR: begin
        if (func3 == INST_JALR) begin
          op1_o         = inst_addr_i;
          op2_o         = four;
          rd_addr_o     = rd;
          reg_wen_o     = 1'b1;
          base_addr_o   = rs1_data_i;
          addr_offset_o = imm_i;
          uses_rs1_o    = 1'b1;
        end else begin
          illegal_o = 1'b1;
        end
      end
      INST_TYPE_LUI: begin
        op1_o     = imm_u;
        rd_addr_o = rd;
        reg_wen_o = 1'b1;
      end
      INST_TYPE_AUIPC: begin
        op1_o     = inst_addr_i;
        op2_o     = imm_u;
        rd_addr_o = rd;
        reg_wen_o = 1'b1;
      end
      INST_TYPE_L: begin
        if (load_f3_ok(func3, RV64)) begin
          base_addr_o   = rs1_data_i;
          addr_offset_o = imm_i;
          rd_addr_o     = rd;
          reg_wen_o     = 1'b1;
          mem_ren_o     = 1'b1;
          uses_rs1_o    = 1'b1;
        end else begin
          illegal_o = 1'b1;
        end
      end
      INST_TYPE_S: begin
        if (store_f3_ok(func3, RV64)) begin
          base_addr_o   = rs1_data_i;
          addr_offset_o = imm_s;
          op2_o         = rs2_data_i;
          mem_wen_o     = 1'b1;
          uses_rs1_o    = 1'b1;
          uses_rs2_o    = 1'b1;
        end else begin
          illegal_o = 1'b1;
        end
      end
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/id_pipe.sv
// Registered decode stage: one-entry output register with valid/ready on both
// sides, flush, and a load-use interlock (held-load check plus down-counter).
//
//   state    | meaning
//   ---------+-----------------------------------------------
//   ST_EMPTY | output register holds nothing, out_valid = 0
//   ST_FULL  | output register holds a decoded instruction
module id_pipe
  import id_pipe_pkg::*;
#(
  parameter int XLEN            = 32,
  parameter int LOAD_USE_CYCLES = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush_i,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     inst_i,
  input  logic [XLEN-1:0] inst_addr_i,
  output logic [4:0]      rs1_addr_o,
  output logic [4:0]      rs2_addr_o,
  input  logic [XLEN-1:0] rs1_data_i,
  input  logic [XLEN-1:0] rs2_data_i,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     inst_o,
  output logic [XLEN-1:0] inst_addr_o,
  output logic [XLEN-1:0] op1_o,
  output logic [XLEN-1:0] op2_o,
  output logic [4:0]      rd_addr_o,
  output logic            reg_wen_o,
  output logic [XLEN-1:0] base_addr_o,
  output logic [XLEN-1:0] addr_offset_o,
  output logic            mem_ren_o,
  output logic            mem_wen_o,
  output logic            illegal_o
);

  out_state_e state_q, state_d;

  logic [XLEN-1:0] dec_op1, dec_op2, dec_base, dec_off;
  logic [4:0]      dec_rd;
  logic            dec_wen, dec_ren, dec_mwen, dec_illegal, dec_uses_rs1, dec_uses_rs2;

  logic [31:0]     inst_q;
  logic [XLEN-1:0] inst_addr_q, op1_q, op2_q, base_addr_q, addr_offset_q;
  logic [4:0]      rd_addr_q;
  logic            reg_wen_q, mem_ren_q, mem_wen_q, illegal_q;

  logic [1:0]      lu_cnt_q, lu_cnt_d;
  logic [4:0]      lu_rd_q, lu_rd_d;

  logic            rs1_hit, rs2_hit, hazard, accept, consume;

  id_decode #(.XLEN(XLEN)) u_decode (
    .inst_i        (inst_i),
    .inst_addr_i   (inst_addr_i),
    .rs1_data_i    (rs1_data_i),
    .rs2_data_i    (rs2_data_i),
    .op1_o         (dec_op1),
    .op2_o         (dec_op2),
    .base_addr_o   (dec_base),
    .addr_offset_o (dec_off),
    .rd_addr_o     (dec_rd),
    .reg_wen_o     (dec_wen),
    .mem_ren_o     (dec_ren),
    .mem_wen_o     (dec_mwen),
    .illegal_o     (dec_illegal),
    .uses_rs1_o    (dec_uses_rs1),
    .uses_rs2_o    (dec_uses_rs2)
  );

  assign rs1_addr_o = inst_i[19:15];
  assign rs2_addr_o = inst_i[24:20];

  assign out_valid = (state_q == ST_FULL);

  // A held load blocks its consumer even in the cycle the load is consumed;
  // afterwards the down-counter keeps blocking for LOAD_USE_CYCLES cycles.
  assign rs1_hit = dec_uses_rs1 && (rs1_addr_o != 5'd0) &&
                   ((out_valid && mem_ren_q && (rs1_addr_o == rd_addr_q)) ||
                    ((lu_cnt_q != 2'd0) && (rs1_addr_o == lu_rd_q)));
  assign rs2_hit = dec_uses_rs2 && (rs2_addr_o != 5'd0) &&
                   ((out_valid && mem_ren_q && (rs2_addr_o == rd_addr_q)) ||
                    ((lu_cnt_q != 2'd0) && (rs2_addr_o == lu_rd_q)));
  assign hazard  = rs1_hit || rs2_hit;

  assign in_ready = rst_n && !flush_i && (!out_valid || out_ready) && !hazard;
  assign accept   = in_valid && in_ready;
  assign consume  = out_valid && out_ready;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_EMPTY: if (accept) state_d = ST_FULL;
      ST_FULL: begin
        if (flush_i)                 state_d = ST_EMPTY;
        else if (consume && !accept) state_d = ST_EMPTY;
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  always_comb begin
    lu_cnt_d = lu_cnt_q;
    lu_rd_d  = lu_rd_q;
    if (flush_i) begin
      lu_cnt_d = 2'd0;
    end else if (consume && mem_ren_q) begin
      lu_rd_d  = rd_addr_q;
      lu_cnt_d = 2'(LOAD_USE_CYCLES);
    end else if (lu_cnt_q != 2'd0) begin
      lu_cnt_d = lu_cnt_q - 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_EMPTY;
      lu_cnt_q <= 2'd0;
      lu_rd_q  <= 5'd0;
    end else begin
      state_q  <= state_d;
      lu_cnt_q <= lu_cnt_d;
      lu_rd_q  <= lu_rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      inst_q        <= '0;
      inst_addr_q   <= '0;
      op1_q         <= '0;
      op2_q         <= '0;
      rd_addr_q     <= '0;
      reg_wen_q     <= 1'b0;
      base_addr_q   <= '0;
      addr_offset_q <= '0;
      mem_ren_q     <= 1'b0;
      mem_wen_q     <= 1'b0;
      illegal_q     <= 1'b0;
    end else if (accept) begin
      inst_q        <= inst_i;
      inst_addr_q   <= inst_addr_i;
      op1_q         <= dec_op1;
      op2_q         <= dec_op2;
      rd_addr_q     <= dec_rd;
      reg_wen_q     <= dec_wen;
      base_addr_q   <= dec_base;
      addr_offset_q <= dec_off;
      mem_ren_q     <= dec_ren;
      mem_wen_q     <= dec_mwen;
      illegal_q     <= dec_illegal;
    end
  end

  assign inst_o        = inst_q;
  assign inst_addr_o   = inst_addr_q;
  assign op1_o         = op1_q;
  assign op2_o         = op2_q;
  assign rd_addr_o     = rd_addr_q;
  assign reg_wen_o     = reg_wen_q;
  assign base_addr_o   = base_addr_q;
  assign addr_offset_o = addr_offset_q;
  assign mem_ren_o     = mem_ren_q;
  assign mem_wen_o     = mem_wen_q;
  assign illegal_o     = illegal_q;

endmodule

// File: tb/tb_id_pipe.sv
// Directed bench for id_pipe: an RV32 instance (LOAD_USE_CYCLES=1) and an
// RV64 instance (LOAD_USE_CYCLES=3), both fed from one bench register file.
module tb_id_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [63:0] rf [32];

  // RV32 instance
  logic        rst_n_a, flush_a, in_valid_a, in_ready_a, out_valid_a, out_ready_a;
  logic        reg_wen_a, mem_ren_a, mem_wen_a, illegal_a;
  logic [31:0] inst_a, inst_o_a, pc_a, pc_o_a, rs1d_a, rs2d_a, op1_a, op2_a, base_a, off_a;
  logic [4:0]  rs1_a, rs2_a, rd_a;

  assign rs1d_a = rf[rs1_a][31:0];
  assign rs2d_a = rf[rs2_a][31:0];

  id_pipe #(.XLEN(32), .LOAD_USE_CYCLES(1)) dut_a (
    .clk(clk), .rst_n(rst_n_a), .flush_i(flush_a),
    .in_valid(in_valid_a), .in_ready(in_ready_a),
    .inst_i(inst_a), .inst_addr_i(pc_a),
    .rs1_addr_o(rs1_a), .rs2_addr_o(rs2_a),
    .rs1_data_i(rs1d_a), .rs2_data_i(rs2d_a),
    .out_valid(out_valid_a), .out_ready(out_ready_a),
    .inst_o(inst_o_a), .inst_addr_o(pc_o_a),
    .op1_o(op1_a), .op2_o(op2_a), .rd_addr_o(rd_a), .reg_wen_o(reg_wen_a),
    .base_addr_o(base_a), .addr_offset_o(off_a),
    .mem_ren_o(mem_ren_a), .mem_wen_o(mem_wen_a), .illegal_o(illegal_a)
  );

  // RV64 instance
  logic        rst_n_b, flush_b, in_valid_b, in_ready_b, out_valid_b, out_ready_b;
  logic        reg_wen_b, mem_ren_b, mem_wen_b, illegal_b;
  logic [31:0] inst_b, inst_o_b;
  logic [63:0] pc_b, pc_o_b, rs1d_b, rs2d_b, op1_b, op2_b, base_b, off_b;
  logic [4:0]  rs1_b, rs2_b, rd_b;

  assign rs1d_b = rf[rs1_b];
  assign rs2d_b = rf[rs2_b];

  id_pipe #(.XLEN(64), .LOAD_USE_CYCLES(3)) dut_b (
    .clk(clk), .rst_n(rst_n_b), .flush_i(flush_b),
    .in_valid(in_valid_b), .in_ready(in_ready_b),
    .inst_i(inst_b), .inst_addr_i(pc_b),
    .rs1_addr_o(rs1_b), .rs2_addr_o(rs2_b),
    .rs1_data_i(rs1d_b), .rs2_data_i(rs2d_b),
    .out_valid(out_valid_b), .out_ready(out_ready_b),
    .inst_o(inst_o_b), .inst_addr_o(pc_o_b),
    .op1_o(op1_b), .op2_o(op2_b), .rd_addr_o(rd_b), .reg_wen_o(reg_wen_b),
    .base_addr_o(base_b), .addr_offset_o(off_b),
    .mem_ren_o(mem_ren_b), .mem_wen_o(mem_wen_b), .illegal_o(illegal_b)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] r_add(input logic [4:0] rd, input logic [4:0] rs1,
                                        input logic [4:0] rs2);
    return {7'b0, rs2, rs1, 3'b000, rd, 7'b0110011};
  endfunction

  localparam logic [31:0] ADDI_M1  = 32'hFFF10093; // addi x1,x2,-1
  localparam logic [31:0] LW_X5    = 32'h00832283; // lw x5,8(x6)
  localparam logic [31:0] ADD_X5   = 32'h001283B3; // add x7,x5,x1
  localparam logic [31:0] LW_X0    = 32'h00832003; // lw x0,8(x6)
  localparam logic [31:0] ADD_X1X0 = 32'h000083B3; // add x7,x1,x0
  localparam logic [31:0] SW_M4    = 32'hFE322E23; // sw x3,-4(x4)
  localparam logic [31:0] BAD_OP   = 32'h00000FFF; // opcode 0x7F, rd field 31
  localparam logic [31:0] BAD_BR   = 32'h00002063; // branch func3 010
  localparam logic [31:0] LD_X5    = 32'h00833283; // ld x5,8(x6)
  localparam logic [31:0] JAL_16   = 32'h010000EF; // jal x1,+16
  localparam logic [31:0] SLLI_33  = 32'h02109093; // slli x1,x1,33

  logic [31:0] stream [8];
  int sent, got;
  logic rdy;

  initial begin
    #100000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = 64'h11 * i;
    rf[2] = 64'd5;
    rf[3] = 64'hDEAD;
    rf[4] = 64'h2000;
    rf[6] = 64'h1000;

    rst_n_a = 0; flush_a = 0; in_valid_a = 0; out_ready_a = 0; inst_a = 0; pc_a = 0;
    rst_n_b = 0; flush_b = 0; in_valid_b = 0; out_ready_b = 0; inst_b = 0; pc_b = 0;
    cyc(); cyc();
    in_valid_a = 1; inst_a = ADDI_M1;
    #2;
    chk("rst_in_ready", in_ready_a, 0);
    chk("rst_out_valid", out_valid_a, 0);
    chk("rst_inst_o", inst_o_a, 0);
    chk("rst_lu_cnt", dut_a.lu_cnt_q, 0);
    in_valid_a = 0;
    cyc();
    rst_n_a = 1; rst_n_b = 1;
    cyc();

    // ADDI x1,x2,-1
    inst_a = ADDI_M1; pc_a = 32'h100; in_valid_a = 1; out_ready_a = 1;
    #2 chk("addi_in_ready", in_ready_a, 1);
    cyc();
    in_valid_a = 0;
    chk("addi_valid", out_valid_a, 1);
    chk("addi_op1", op1_a, 5);
    chk("addi_op2", op2_a, 32'hFFFFFFFF);
    chk("addi_rd", rd_a, 1);
    chk("addi_wen", reg_wen_a, 1);
    chk("addi_pc", pc_o_a, 32'h100);
    chk("addi_illegal", illegal_a, 0);
    cyc();

    // R-type stream with out_ready toggling
    for (int i = 0; i < 8; i++) stream[i] = r_add(5'(i + 10), 5'(i + 1), 5'(i + 2));
    sent = 0; got = 0; rdy = 1;
    for (int c = 0; c < 60 && got < 8; c++) begin
      out_ready_a = rdy;
      in_valid_a  = (sent < 8);
      inst_a      = stream[(sent < 8) ? sent : 0];
      #2;
      if (out_valid_a) begin
        chk("stream_inst", inst_o_a, stream[got]);
        chk("stream_op1", op1_a, rf[got + 1][31:0]);
        chk("stream_op2", op2_a, rf[got + 2][31:0]);
        if (out_ready_a) got++;
      end
      if (in_valid_a && in_ready_a) sent++;
      rdy = !rdy;
      cyc();
    end
    chk("stream_count", got, 8);
    in_valid_a = 0; out_ready_a = 1;
    cyc(); cyc();

    // Load-use: LW x5 then ADD x7,x5,x1
    inst_a = LW_X5; in_valid_a = 1; out_ready_a = 0;
    #2 chk("lw_in_ready", in_ready_a, 1);
    cyc();
    chk("lw_ren", mem_ren_a, 1);
    chk("lw_base", base_a, 32'h1000);
    chk("lw_off", off_a, 8);
    chk("lw_rd", rd_a, 5);
    chk("lw_wen", reg_wen_a, 1);
    inst_a = ADD_X5;
    #2 chk("lu_full_block", in_ready_a, 0);
    cyc();
    out_ready_a = 1;
    #2 chk("lu_held_block", in_ready_a, 0);
    cyc();
    #1;
    chk("lu_cnt_loaded", dut_a.lu_cnt_q, 1);
    chk("lu_out_empty", out_valid_a, 0);
    chk("lu_cnt_block", in_ready_a, 0);
    cyc();
    chk("lu_release", in_ready_a, 1);
    cyc();
    chk("lu_add_valid", out_valid_a, 1);
    chk("lu_add_inst", inst_o_a, ADD_X5);
    chk("lu_add_op1", op1_a, rf[5][31:0]);
    inst_a = LW_X0;
    #2 chk("lw0_in_ready", in_ready_a, 1);
    cyc();
    inst_a = ADD_X1X0;
    #2 chk("x0_no_stall", in_ready_a, 1);
    cyc();
    chk("x0_add_inst", inst_o_a, ADD_X1X0);
    in_valid_a = 0;
    cyc(); cyc();

    // Store, illegal encodings, JAL, LD on RV32
    in_valid_a = 1; inst_a = SW_M4;
    cyc();
    chk("sw_wen_mem", mem_wen_a, 1);
    chk("sw_off", off_a, 32'hFFFFFFFC);
    chk("sw_reg_wen", reg_wen_a, 0);
    chk("sw_base", base_a, 32'h2000);
    chk("sw_op2", op2_a, 32'hDEAD);
    chk("sw_ren", mem_ren_a, 0);
    inst_a = BAD_OP;
    cyc();
    chk("ill_flag", illegal_a, 1);
    chk("ill_valid", out_valid_a, 1);
    chk("ill_rd", rd_a, 0);
    chk("ill_inst", inst_o_a, BAD_OP);
    inst_a = BAD_BR;
    cyc();
    chk("ill_br_f3", illegal_a, 1);
    inst_a = LD_X5;
    cyc();
    chk("ld_rv32_illegal", illegal_a, 1);
    chk("ld_rv32_ren", mem_ren_a, 0);
    inst_a = JAL_16; pc_a = 32'h300;
    cyc();
    chk("jal_op1", op1_a, 32'h300);
    chk("jal_op2", op2_a, 4);
    chk("jal_off", off_a, 16);
    chk("jal_rd", rd_a, 1);
    chk("jal_illegal", illegal_a, 0);

    // Flush while FULL, not ready, new instruction offered
    inst_a = ADDI_M1; out_ready_a = 0;
    cyc();
    inst_a = SW_M4; flush_a = 1;
    #2 chk("flush_in_ready", in_ready_a, 0);
    cyc();
    flush_a = 0; in_valid_a = 0;
    chk("flush_valid", out_valid_a, 0);
    chk("flush_lu_cnt_a", dut_a.lu_cnt_q, 0);
    cyc();
    chk("flush_no_accept", out_valid_a, 0);

    // RV64 instance
    out_ready_b = 1; in_valid_b = 1; inst_b = SLLI_33; pc_b = 64'h400;
    cyc();
    chk("slli64_op2", op2_b, 33);
    chk("slli64_op1", op1_b, 64'h11);
    inst_b = ADDI_M1;
    cyc();
    chk("addi64_op2", op2_b, 64'hFFFFFFFFFFFFFFFF);
    inst_b = LD_X5;
    cyc();
    chk("ld64_ren", mem_ren_b, 1);
    chk("ld64_illegal", illegal_b, 0);
    in_valid_b = 0;
    cyc();
    chk("ld64_lu_cnt", dut_b.lu_cnt_q, 3);
    flush_b = 1;
    cyc();
    flush_b = 0;
    chk("flush64_lu_cnt", dut_b.lu_cnt_q, 0);
    inst_b = ADD_X5; in_valid_b = 1; out_ready_b = 0;
    #1 chk("flush64_unblock", in_ready_b, 1);
    cyc();
    chk("add64_valid", out_valid_b, 1);
    rst_n_b = 0;
    cyc();
    chk("rst64_valid", out_valid_b, 0);
    chk("rst64_inst", inst_o_b, 0);
    chk("rst64_op1", op1_b, 0);
    chk("rst64_op2", op2_b, 0);
    chk("rst64_pc", pc_o_b, 0);
    chk("rst64_rd", rd_b, 0);
    chk("rst64_wen", reg_wen_b, 0);
    chk("rst64_in_ready", in_ready_b, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
